demux_2b_sync: RTL and testbench

Clocked 1-to-2 four-phase handshake demultiplexer. It is the receiving end of the two-input arbiter tree's merged request channel: it takes the single `req_in`/`ack_in` pair plus the `sel` tag and steers each transaction to one of two downstream four-phase channels. Asynchronous handshake inputs are resynchronised into the `clk` domain. Per-channel transaction counters and a sticky protocol-error flag support debug and verification.

---
 rtl/demux_2b_sync.sv | 126 ++++++++++++
 tb/tb_demux_2b_sync.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/demux_2b_sync.sv
// ============================================================================
// Module  : demux_2b_sync
// Brief   : Clocked 1-to-2 four-phase handshake demultiplexer with input
//           resynchronisers, per-channel transaction counters and error flag.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module demux_2b_sync #(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_in,
    input  logic             sel_in,
    output logic             ack_in,
    output logic [1:0]       req_out,
    input  logic [1:0]       ack_out,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1,
    output logic             busy,
    output logic             err
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_REQ  = 2'd1;
    localparam logic [1:0] c_ACK  = 2'd2;
    localparam logic [1:0] c_RTZ  = 2'd3;

    logic [SYNC_STAGES-1:0]      r_req_sync;
    logic [1:0][SYNC_STAGES-1:0] r_ack_sync;
    logic [1:0]                  r_state;
    logic                        r_sel_q;
    logic                        r_ack_in;
    logic [1:0]                  r_req_out;
    logic [CNT_W-1:0]            r_cnt0;
    logic [CNT_W-1:0]            r_cnt1;
    logic                        r_err;

    logic       w_req_s;
    logic [1:0] w_ack_s;
    logic       w_ack_sel;
    logic       w_ack_oth;

    // Plain flop chains; the MSB of each chain is the clk-domain view.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_req_sync <= '0;
            r_ack_sync <= '0;
        end else begin
            r_req_sync    <= {r_req_sync[SYNC_STAGES-2:0], req_in};
            r_ack_sync[0] <= {r_ack_sync[0][SYNC_STAGES-2:0], ack_out[0]};
            r_ack_sync[1] <= {r_ack_sync[1][SYNC_STAGES-2:0], ack_out[1]};
        end
    end

    assign w_req_s   = r_req_sync[SYNC_STAGES-1];
    assign w_ack_s   = {r_ack_sync[1][SYNC_STAGES-1], r_ack_sync[0][SYNC_STAGES-1]};
    assign w_ack_sel = r_sel_q ? w_ack_s[1] : w_ack_s[0];
    assign w_ack_oth = r_sel_q ? w_ack_s[0] : w_ack_s[1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= c_IDLE;
            r_sel_q   <= 1'b0;
            r_ack_in  <= 1'b0;
            r_req_out <= 2'b00;
            r_cnt0    <= '0;
            r_cnt1    <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    // sel_in is only trusted here, where req_s=1 implies it is stable.
                    if (w_req_s) begin
                        r_sel_q            <= sel_in;
                        r_req_out          <= 2'b00;
                        r_req_out[sel_in]  <= 1'b1;
                        r_state            <= c_REQ;
                    end
                end
                c_REQ: begin
                    if (w_ack_sel) begin
                        r_ack_in <= 1'b1;
                        r_state  <= c_ACK;
                    end
                end
                c_ACK: begin
                    if (!w_req_s) begin
                        r_req_out <= 2'b00;
                        r_state   <= c_RTZ;
                    end
                end
                c_RTZ: begin
                    if (!w_ack_sel) begin
                        r_ack_in <= 1'b0;
                        if (r_sel_q) r_cnt1 <= r_cnt1 + CNT_W'(1);
                        else         r_cnt0 <= r_cnt0 + CNT_W'(1);
                        r_state  <= c_IDLE;
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (r_state == c_IDLE) begin
            if (w_ack_s != 2'b00) r_err <= 1'b1;
        end else if (w_ack_oth) begin
            r_err <= 1'b1;
        end
    end

    assign ack_in  = r_ack_in;
    assign req_out = r_req_out;
    assign cnt0    = r_cnt0;
    assign cnt1    = r_cnt1;
    assign busy    = (r_state != c_IDLE);
    assign err     = r_err;

endmodule

`default_nettype wire

// File: tb/tb_demux_2b_sync.sv
// ============================================================================
// Module  : tb_demux_2b_sync
// Brief   : Self-checking bench for demux_2b_sync (table, random, corner cases).
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_demux_2b_sync;

    localparam int SS  = 2;
    localparam int CW  = 8;
    localparam int CWW = 2;
    localparam int LAT = SS + 1;

    logic           clk;
    logic           rst;
    logic           req_in;
    logic           sel_in;
    logic [1:0]     ack_out;
    wire            ack_in, ack_in_w;
    wire  [1:0]     req_out, req_out_w;
    wire  [CW-1:0]  cnt0, cnt1;
    wire  [CWW-1:0] cnt0_w, cnt1_w;
    wire            busy, busy_w, err, err_w;

    demux_2b_sync #(.SYNC_STAGES(SS), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .req_in(req_in), .sel_in(sel_in),
        .ack_in(ack_in), .req_out(req_out), .ack_out(ack_out),
        .cnt0(cnt0), .cnt1(cnt1), .busy(busy), .err(err)
    );

    // Narrow-counter copy sharing the same stimulus, used for wrap behaviour.
    demux_2b_sync #(.SYNC_STAGES(SS), .CNT_W(CWW)) dut_w (
        .clk(clk), .rst(rst), .req_in(req_in), .sel_in(sel_in),
        .ack_in(ack_in_w), .req_out(req_out_w), .ack_out(ack_out),
        .cnt0(cnt0_w), .cnt1(cnt1_w), .busy(busy_w), .err(err_w)
    );

    typedef struct {
        logic sel;
        int   exp_cnt0;
        int   exp_cnt1;
    } vec_t;

    vec_t tbl [6];
    int   n_chk = 0;
    int   n_fail = 0;
    int   m_cnt [2];
    bit   both_seen = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (req_out == 2'b11 || req_out_w == 2'b11) both_seen = 1'b1;
    end

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic wait_req(input logic [1:0] exp, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (req_out !== exp && n < 40);
        chk("req_out_level", int'(req_out), int'(exp));
    endtask

    task automatic wait_ack(input logic exp, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (ack_in !== exp && n < 40);
        chk("ack_in_level", int'(ack_in), int'(exp));
    endtask

    task automatic pause(input int maxd);
        repeat ($urandom_range(0, maxd)) @(negedge clk);
    endtask

    task automatic check_counts();
        chk("cnt0",   int'(cnt0),   m_cnt[0] % (1 << CW));
        chk("cnt1",   int'(cnt1),   m_cnt[1] % (1 << CW));
        chk("cnt0_w", int'(cnt0_w), m_cnt[0] % (1 << CWW));
        chk("cnt1_w", int'(cnt1_w), m_cnt[1] % (1 << CWW));
    endtask

    task automatic run_txn(input logic s, input int maxd);
        int n;
        logic [1:0] oh;
        oh = s ? 2'b10 : 2'b01;
        sel_in = s;
        req_in = 1'b1;
        wait_req(oh, n);
        chk("req_rise_lat", n, LAT);
        chk("busy_in_txn", int'(busy), 1);
        pause(maxd);
        ack_out[s] = 1'b1;
        wait_ack(1'b1, n);
        chk("ack_rise_lat", n, LAT);
        pause(maxd);
        req_in = 1'b0;
        wait_req(2'b00, n);
        chk("req_fall_lat", n, LAT);
        chk("ack_held_rtz", int'(ack_in), 1);
        pause(maxd);
        ack_out[s] = 1'b0;
        wait_ack(1'b0, n);
        chk("ack_fall_lat", n, LAT);
        m_cnt[s] = m_cnt[s] + 1;
        check_counts();
        chk("busy_after_txn", int'(busy), 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        m_cnt[0] = 0;
        m_cnt[1] = 0;
    endtask

    initial begin
        int n;
        tbl[0] = '{1'b0, 1, 0};
        tbl[1] = '{1'b1, 1, 1};
        tbl[2] = '{1'b0, 2, 1};
        tbl[3] = '{1'b0, 3, 1};
        tbl[4] = '{1'b1, 3, 2};
        tbl[5] = '{1'b0, 4, 2};
        m_cnt[0] = 0;
        m_cnt[1] = 0;

        rst = 1'b1; req_in = 1'b0; sel_in = 1'b0; ack_out = 2'b00;
        repeat (2) @(negedge clk);
        chk("rst_req_out", int'(req_out), 0);
        chk("rst_ack_in",  int'(ack_in), 0);
        chk("rst_cnt0",    int'(cnt0), 0);
        chk("rst_cnt1",    int'(cnt1), 0);
        chk("rst_busy",    int'(busy), 0);
        chk("rst_err",     int'(err), 0);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        chk("idle_req_out", int'(req_out), 0);
        chk("idle_ack_in",  int'(ack_in), 0);
        chk("idle_busy",    int'(busy | busy_w), 0);

        // Single transaction on channel 1, immediate responses.
        run_txn(1'b1, 0);
        chk("single_cnt1", int'(cnt1), 1);
        chk("single_cnt0", int'(cnt0), 0);

        do_reset();
        for (int i = 0; i < 6; i++) begin
            run_txn(tbl[i].sel, 0);
            chk("tbl_cnt0", int'(cnt0), tbl[i].exp_cnt0);
            chk("tbl_cnt1", int'(cnt1), tbl[i].exp_cnt1);
        end
        chk("tbl_err", int'(err), 0);

        for (int i = 0; i < 24; i++) run_txn(1'($urandom_range(0, 1)), 3);
        chk("rand_err", int'(err | err_w), 0);
        chk("never_both", int'(both_seen), 0);

        do_reset();
        for (int i = 0; i < 5; i++) run_txn(1'b0, 1);
        chk("wrap_cnt0_w", int'(cnt0_w), 1);
        chk("wrap_cnt0", int'(cnt0), 5);

        // Stray ack on the unselected channel during REQ.
        sel_in = 1'b0;
        req_in = 1'b1;
        wait_req(2'b01, n);
        chk("perr_pre_err", int'(err), 0);
        ack_out[1] = 1'b1;
        repeat (4) @(negedge clk);
        ack_out[1] = 1'b0;
        repeat (3) @(negedge clk);
        chk("perr_err_set", int'(err), 1);
        chk("perr_state_req", int'(req_out), 1);
        ack_out[0] = 1'b1;
        wait_ack(1'b1, n);
        req_in = 1'b0;
        wait_req(2'b00, n);
        ack_out[0] = 1'b0;
        wait_ack(1'b0, n);
        m_cnt[0] = m_cnt[0] + 1;
        check_counts();
        repeat (5) @(negedge clk);
        chk("perr_err_sticky", int'(err & err_w), 1);

        // Asynchronous reset while in ACK, request still asserted.
        sel_in = 1'b1;
        req_in = 1'b1;
        wait_req(2'b10, n);
        ack_out[1] = 1'b1;
        wait_ack(1'b1, n);
        #2;
        rst = 1'b1;
        ack_out[1] = 1'b0;
        #1;
        chk("mrst_ack_in",  int'(ack_in), 0);
        chk("mrst_req_out", int'(req_out), 0);
        chk("mrst_busy",    int'(busy), 0);
        chk("mrst_err",     int'(err), 0);
        chk("mrst_cnt0",    int'(cnt0), 0);
        @(negedge clk);
        rst = 1'b0;
        m_cnt[0] = 0;
        m_cnt[1] = 0;
        wait_req(2'b10, n);
        chk("mrst_restart_lat", n, LAT);
        ack_out[1] = 1'b1;
        wait_ack(1'b1, n);
        req_in = 1'b0;
        wait_req(2'b00, n);
        ack_out[1] = 1'b0;
        wait_ack(1'b0, n);
        m_cnt[1] = m_cnt[1] + 1;
        check_counts();
        chk("final_never_both", int'(both_seen), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", n_chk);
        $fatal(1);
    end

endmodule

`default_nettype wire
